// File: rtl/mdu_unit_pkg.sv
// Shared MDU definitions: operation codes used by both the ID/EX decode and
// the multiply/divide unit, the unit's control states and small decode helpers.
package mdu_unit_pkg;

  typedef enum logic [3:0] {
    MDU_NONE  = 4'd0,
    MDU_MULT  = 4'd1,
    MDU_MULTU = 4'd2,
    MDU_DIV   = 4'd3,
    MDU_DIVU  = 4'd4,
    MDU_MFHI  = 4'd5,
    MDU_MFLO  = 4'd6,
    MDU_MTHI  = 4'd7,
    MDU_MTLO  = 4'd8
  } mdu_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } mdu_state_e;

  // Multi-cycle arithmetic ops that occupy the unit and raise busy.
  function automatic logic is_muldiv(input logic [3:0] op);
    return (op == MDU_MULT) || (op == MDU_MULTU) ||
           (op == MDU_DIV)  || (op == MDU_DIVU);
  endfunction

  // Divide ops; these use the longer latency.
  function automatic logic is_div(input logic [3:0] op);
    return (op == MDU_DIV) || (op == MDU_DIVU);
  endfunction

  // Single-cycle writes of A into HI or LO.
  function automatic logic is_move_to(input logic [3:0] op);
    return (op == MDU_MTHI) || (op == MDU_MTLO);
  endfunction

endpackage

// File: rtl/mdu_unit_if.sv
// EX-stage connection between the pipeline and the multiply/divide unit.
// The pipeline (master) presents the op and operands; the unit (slave)
// answers with start/busy, the architectural HI/LO and the mfhi/mflo value.
interface mdu_unit_if;

  logic [3:0]  MDUOp;
  logic [31:0] A;
  logic [31:0] B;
  logic        cancel;
  logic        start;
  logic        busy;
  logic [31:0] HI;
  logic [31:0] LO;
  logic [31:0] Out;

  modport master (
    output MDUOp, A, B, cancel,
    input  start, busy, HI, LO, Out
  );

  modport slave (
    input  MDUOp, A, B, cancel,
    output start, busy, HI, LO, Out
  );

endinterface

// File: rtl/mdu_unit_calc.sv
// Purely combinational arithmetic for the MDU. Produces the 64-bit {hi,lo}
// result for mult/multu/div/divu and flags a divide by zero so the caller
// can leave HI/LO untouched. Signed division works on magnitudes so that the
// 0x80000000 / -1 corner wraps to 0x80000000 instead of overflowing.
module mdu_calc
  import mdu_unit_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [63:0] result,
  output logic        div_by_zero
);

  logic signed [63:0] a_sext;
  logic signed [63:0] b_sext;
  logic signed [63:0] sprod;
  logic [63:0]        uprod;
  logic [31:0]        a_mag;
  logic [31:0]        b_mag;
  logic [31:0]        smag_div;
  logic [31:0]        udiv_b;
  logic [31:0]        squo_mag;
  logic [31:0]        srem_mag;
  logic [31:0]        squo;
  logic [31:0]        srem;
  logic [31:0]        uquo;
  logic [31:0]        urem;

  // Products, magnitudes and quotients; a zero divisor is swapped for 1 to keep the dividers defined.
  always_comb begin
    a_sext      = {{32{a[31]}}, a};
    b_sext      = {{32{b[31]}}, b};
    sprod       = a_sext * b_sext;
    uprod       = {32'd0, a} * {32'd0, b};
    div_by_zero = is_div(op) && (b == 32'd0);
    a_mag       = a[31] ? (32'd0 - a) : a;
    b_mag       = b[31] ? (32'd0 - b) : b;
    smag_div    = (b_mag == 32'd0) ? 32'd1 : b_mag;
    udiv_b      = (b == 32'd0) ? 32'd1 : b;
    squo_mag    = a_mag / smag_div;
    srem_mag    = a_mag % smag_div;
    squo        = (a[31] ^ b[31]) ? (32'd0 - squo_mag) : squo_mag;
    srem        = a[31] ? (32'd0 - srem_mag) : srem_mag;
    uquo        = a / udiv_b;
    urem        = a % udiv_b;
  end

  // Select the result for the requested op; anything else yields zero.
  always_comb begin
    result = 64'd0;
    case (op)
      MDU_MULT:  result = sprod;
      MDU_MULTU: result = uprod;
      MDU_DIV:   result = {srem, squo};
      MDU_DIVU:  result = {urem, uquo};
      default:   result = 64'd0;
    endcase
  end

endmodule

// File: rtl/mdu_unit.sv
// Multiply/divide unit for the EX stage. Arithmetic ops are computed at issue
// into pending registers, then held back for a fixed latency while busy is
// high so the hazard unit sees realistic timing; HI/LO update only when the
// countdown expires. mthi/mtlo write immediately when the unit is idle.
module mdu_unit
  import mdu_unit_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic      clk,
  input  logic      reset,
  mdu_unit_if.slave bus
);

  localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES) + 1;

  mdu_state_e         state;
  logic [CNT_W-1:0]   count;
  logic [63:0]        pend;
  logic               pend_dz;
  logic [31:0]        hi;
  logic [31:0]        lo;
  logic [63:0]        calc_result;
  logic               calc_dz;
  logic               move_ok;

  mdu_calc u_calc (
    .op          (bus.MDUOp),
    .a           (bus.A),
    .b           (bus.B),
    .result      (calc_result),
    .div_by_zero (calc_dz)
  );

  assign bus.busy  = (state == ST_BUSY);
  assign bus.start = is_muldiv(bus.MDUOp) && !bus.cancel && (state == ST_IDLE);
  assign move_ok   = is_move_to(bus.MDUOp) && !bus.cancel && (state == ST_IDLE);
  assign bus.HI    = hi;
  assign bus.LO    = lo;

  // mfhi/mflo read path straight from the architectural registers.
  always_comb begin
    bus.Out = 32'd0;
    if (bus.MDUOp == MDU_MFHI) begin
      bus.Out = hi;
    end else if (bus.MDUOp == MDU_MFLO) begin
      bus.Out = lo;
    end
  end

  // Issue/countdown/commit control plus HI/LO moves; reset drops any in-flight result.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= ST_IDLE;
      count   <= '0;
      pend    <= 64'd0;
      pend_dz <= 1'b0;
      hi      <= 32'd0;
      lo      <= 32'd0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            pend    <= calc_result;
            pend_dz <= calc_dz;
            count   <= is_div(bus.MDUOp) ? CNT_W'(DIV_CYCLES - 1) : CNT_W'(MULT_CYCLES - 1);
            state   <= ST_BUSY;
          end else if (move_ok) begin
            if (bus.MDUOp == MDU_MTHI) begin
              hi <= bus.A;
            end else begin
              lo <= bus.A;
            end
          end
        end
        ST_BUSY: begin
          if (count == '0) begin
            state <= ST_IDLE;
            if (!pend_dz) begin
              hi <= pend[63:32];
              lo <= pend[31:0];
            end
          end else begin
            count <= count - CNT_W'(1);
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
